// File: rtl/uart_bram_pkg.sv
// UART block-RAM controller shared definitions.
// State encoding and command/length constants.
package uart_bram_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_AHI,
    GET_ALO,
    WR_DATA,
    GET_LEN,
    RD_REQ,
    RD_LAT,
    TX_LOAD,
    TX_WAIT
  } state_t;

  localparam int CMD_RD_BIT = 7;
  localparam int LEN_W      = 9;

endpackage

// File: rtl/uart_bram_ctrl.sv
// UART command parser driving a byte-wide block RAM.
// Writes stream rx bytes into RAM; reads stream RAM bytes to tx.
module uart_bram_ctrl
  import uart_bram_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_block_timeout,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              cmd_err
);

  state_t             state;
  logic               is_rd;
  logic [7:0]         addr_hi;
  logic [ADDR_W-1:0]  addr;
  logic [LEN_W-1:0]   cnt;
  logic               rd_first;
  logic [7:0]         rd_buf;
  logic               wait_first;
  logic [15:0]        full_addr;
  logic [7:0]         rd_byte;

  assign full_addr = {addr_hi, rx_data};
  // RAM data is only guaranteed on the first TX_LOAD cycle; hold it after.
  assign rd_byte   = rd_first ? ram_rdata : rd_buf;
  assign busy      = (state != IDLE);

  // Command FSM with registered RAM/TX strobes and inline counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      is_rd      <= 1'b0;
      addr_hi    <= '0;
      addr       <= '0;
      cnt        <= '0;
      rd_first   <= 1'b0;
      rd_buf     <= '0;
      wait_first <= 1'b0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      cmd_err    <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      tx_start <= 1'b0;
      cmd_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_data_valid) begin
            is_rd <= rx_data[CMD_RD_BIT];
            state <= GET_AHI;
          end
        end
        GET_AHI: begin
          if (rx_block_timeout) begin
            cmd_err <= 1'b1;
            state   <= IDLE;
          end else if (rx_data_valid) begin
            addr_hi <= rx_data;
            state   <= GET_ALO;
          end
        end
        GET_ALO: begin
          if (rx_block_timeout) begin
            cmd_err <= 1'b1;
            state   <= IDLE;
          end else if (rx_data_valid) begin
            addr  <= ADDR_W'(full_addr);
            state <= is_rd ? GET_LEN : WR_DATA;
          end
        end
        WR_DATA: begin
          if (rx_data_valid) begin
            ram_we    <= 1'b1;
            ram_wdata <= rx_data;
            ram_addr  <= addr;
            addr      <= addr + ADDR_W'(1);
          end
          if (rx_block_timeout) begin
            state <= IDLE;
          end
        end
        GET_LEN: begin
          if (rx_block_timeout) begin
            cmd_err <= 1'b1;
            state   <= IDLE;
          end else if (rx_data_valid) begin
            cnt   <= {1'b0, rx_data} + LEN_W'(1);
            state <= RD_REQ;
          end
        end
        RD_REQ: begin
          ram_re   <= 1'b1;
          ram_addr <= addr;
          state    <= RD_LAT;
        end
        RD_LAT: begin
          rd_first <= 1'b1;
          state    <= TX_LOAD;
        end
        TX_LOAD: begin
          rd_first <= 1'b0;
          rd_buf   <= rd_byte;
          if (!tx_busy) begin
            tx_start   <= 1'b1;
            tx_data    <= rd_byte;
            wait_first <= 1'b1;
            state      <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!tx_busy) begin
            cnt   <= cnt - LEN_W'(1);
            addr  <= addr + ADDR_W'(1);
            state <= (cnt != LEN_W'(1)) ? RD_REQ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
